// File: rtl/eth_payload_rx.sv
// RMII frame receiver. It hunts for preamble and SFD, filters on the
// destination address (station MAC or broadcast), skips the rest of the
// header, and re-emits the payload one dibit per cycle, MSB dibit first.
module eth_payload_rx #(
  parameter logic [47:0] MAC_ADDR        = 48'h69_69_5A_06_54_91,
  parameter bit          ALLOW_BROADCAST = 1'b1
) (
  input  logic        eth_refclk,
  input  logic        rst,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        frame_done,
  output logic        frame_drop,
  output logic [10:0] byte_count
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, HEADER, PAYLOAD, DRAIN, DROP
  } state_t;

  localparam logic [4:0] PRE_MIN   = 5'd28;
  localparam logic [4:0] PRE_SAT   = 5'd31;
  localparam logic [5:0] DEST_LAST = 6'd23;
  localparam logic [5:0] HDR_LAST  = 6'd55;

  // The destination arrives byte by byte, each byte LSB dibit first. This lays
  // out MAC_ADDR in that arrival order so dibit k sits at bits [2k+1:2k].
  function automatic logic [63:0] dest_dibits(input logic [47:0] mac);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 24; k++) begin
      r[2*k +: 2] = mac[40 - 8*(k/4) + 2*(k%4) +: 2];
    end
    return r;
  endfunction

  localparam logic [63:0] DEST_DIBITS = dest_dibits(MAC_ADDR);

  state_t      state, state_d;
  logic [4:0]  run_cnt;    // consecutive 01 dibits seen in the preamble
  logic [5:0]  hdr_cnt;    // header dibit index, 0..55
  logic        mac_ok;     // every destination dibit so far matched MAC_ADDR
  logic        bc_ok;      // every destination dibit so far was 11
  logic        armed;      // a crsdv low has been seen since reset
  logic [5:0]  in_buf;     // up to three earlier dibits of the byte being collected
  logic [1:0]  in_cnt;
  logic [7:0]  out_sr;     // byte being emitted, next dibit in [7:6]
  logic [2:0]  out_cnt;    // dibits still to emit from out_sr
  logic        mac_hit, bc_hit, dest_ok;
  logic        drop_d, done_d;
  logic        byte_load;

  assign byte_load = (state == PAYLOAD) && crsdv && (in_cnt == 2'd3);

  // Next-state decode plus the frame_done / frame_drop strobes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state;
    drop_d  = 1'b0;
    done_d  = 1'b0;
    mac_hit = (rxd == DEST_DIBITS[{hdr_cnt[4:0], 1'b0} +: 2]);
    bc_hit  = (rxd == 2'b11);
    dest_ok = (mac_ok && mac_hit) || (ALLOW_BROADCAST && bc_ok && bc_hit);
    case (state)
      IDLE: begin
        if (armed && crsdv && rxd == 2'b01) state_d = PREAMBLE;
      end
      PREAMBLE: begin
        if (!crsdv) begin
          state_d = IDLE;
        end else if (rxd == 2'b01) begin
          state_d = PREAMBLE;
        end else if (rxd == 2'b11 && run_cnt >= PRE_MIN) begin
          state_d = HEADER;
        end else begin
          state_d = DROP;
          drop_d  = 1'b1;
        end
      end
      HEADER: begin
        if (!crsdv) begin
          state_d = IDLE;
          drop_d  = 1'b1;
        end else if (hdr_cnt == DEST_LAST && !dest_ok) begin
          state_d = DROP;
          drop_d  = 1'b1;
        end else if (hdr_cnt == HDR_LAST) begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!crsdv) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_cnt == 3'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      DROP: begin
        if (!crsdv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge eth_refclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Counters, byte assembly, output shifter and registered outputs.
  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      run_cnt    <= '0;
      hdr_cnt    <= '0;
      mac_ok     <= 1'b0;
      bc_ok      <= 1'b0;
      armed      <= 1'b0;
      in_buf     <= '0;
      in_cnt     <= '0;
      out_sr     <= '0;
      out_cnt    <= '0;
      axiov      <= 1'b0;
      axiod      <= 2'b00;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      byte_count <= '0;
    end else begin
      frame_drop <= drop_d;
      frame_done <= done_d;

      // A frame already in flight when reset released must not be picked up.
      if (!crsdv) armed <= 1'b1;

      case (state)
        IDLE: run_cnt <= 5'd1;
        PREAMBLE: begin
          if (rxd == 2'b01 && run_cnt != PRE_SAT) run_cnt <= run_cnt + 5'd1;
          hdr_cnt <= '0;
          mac_ok  <= 1'b1;
          bc_ok   <= 1'b1;
        end
        HEADER: begin
          hdr_cnt <= hdr_cnt + 6'd1;
          mac_ok  <= mac_ok & mac_hit;
          bc_ok   <= bc_ok & bc_hit;
        end
        default: ;
      endcase

      // Collect dibits; anything short of a whole byte is thrown away on exit.
      if (state == PAYLOAD && crsdv) begin
        in_buf <= {rxd, in_buf[5:2]};
        in_cnt <= in_cnt + 2'd1;
      end else begin
        in_buf <= '0;
        in_cnt <= '0;
      end

      // Emit the current byte while the next one is being collected.
      if (out_cnt != 3'd0) begin
        axiov <= 1'b1;
        axiod <= out_sr[7:6];
      end else begin
        axiov <= 1'b0;
        axiod <= 2'b00;
      end

      if (byte_load) begin
        out_sr  <= {rxd, in_buf};
        out_cnt <= 3'd4;
      end else if (out_cnt != 3'd0) begin
        out_sr  <= {out_sr[5:0], 2'b00};
        out_cnt <= out_cnt - 3'd1;
      end

      if (state == HEADER && state_d == PAYLOAD) begin
        byte_count <= '0;
      end else if (out_cnt == 3'd4 && byte_count != 11'h7FF) begin
        byte_count <= byte_count + 11'd1;
      end
    end
  end

endmodule

// File: doc/eth_payload_rx.md
ETH_PAYLOAD_RX -- requirements
Module: eth_payload_rx

Interface
REQ-001 Parameter MAC_ADDR, default 48'h69_69_5A_06_54_91, station address accepted as destination.
REQ-002 Parameter ALLOW_BROADCAST, default 1, when 1 destination 48'hFF_FF_FF_FF_FF_FF is also accepted.
REQ-003 eth_refclk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 crsdv  in  1  RMII carrier-sense/data-valid.
REQ-006 rxd  in  2  RMII receive dibit, LSB dibit of each byte first.
REQ-007 axiov  out  1  payload dibit valid, feeds matrix loader axiiv.
REQ-008 axiod  out  2  payload dibit, MSB dibit of each byte first, feeds matrix loader axiid.
REQ-009 frame_done  out  1  one-cycle pulse, accepted frame fully emitted.
REQ-010 frame_drop  out  1  one-cycle pulse, frame rejected or truncated.
REQ-011 byte_count  out  11  payload bytes emitted in current/last accepted frame, saturates at 2047.

Function
REQ-012 The block SHALL implement states IDLE, PREAMBLE, HEADER, PAYLOAD, DRAIN, DROP; all outputs registered.
REQ-013 IDLE: crsdv=1 and rxd=01 -> PREAMBLE with run count 1; any other input stays IDLE.
REQ-014 PREAMBLE: rxd=01 increments run count (saturating at 31); rxd=11 with count>=28 -> HEADER; rxd=11 with count<28, or rxd=00/10 -> DROP; crsdv=0 -> IDLE silently.
REQ-015 HEADER SHALL consume exactly 56 dibits (dest 24, src 24, ethertype 8), nothing emitted.
REQ-016 Destination dibit k (0..23), byte b=k/4, d=k%4, SHALL be compared to MAC_ADDR[47-8b-:8] bits [2d+1:2d] and to 2'b11 for broadcast.
REQ-017 After dibit 23, if neither MAC match nor (ALLOW_BROADCAST and broadcast match) -> DROP.
REQ-018 After dibit 55 with match -> PAYLOAD, byte_count cleared to 0.
REQ-019 PAYLOAD: dibits collected into a 4-dibit input buffer; on the 4th dibit of a byte the byte is moved to an output shift register.
REQ-020 A byte whose dibits are sampled at edges t..t+3 SHALL appear on axiod at edges t+4..t+7 as bits [7:6],[5:4],[3:2],[1:0] with axiov=1; byte_count increments at edge t+4.
REQ-021 Back-to-back bytes SHALL give continuous axiov with no gap; input buffer and output register operate concurrently.
REQ-022 FCS bytes are payload to this block and SHALL be passed through unmodified; no CRC check.
REQ-023 PAYLOAD with crsdv=0 -> DRAIN; partial byte (1-3 dibits) SHALL be discarded without emission.
REQ-024 DRAIN: finish emitting the output register; the edge after the last axiov=1 cycle SHALL pulse frame_done and go IDLE; if nothing pending, frame_done pulses the edge after crsdv=0 is sampled.
REQ-025 HEADER with crsdv=0 SHALL pulse frame_drop and go IDLE.
REQ-026 DROP SHALL pulse frame_drop on entry, ignore input, and return to IDLE on first crsdv=0.
REQ-027 axiov=0 implies axiod=00.
REQ-028 frame_done and frame_drop SHALL never be asserted in the same cycle.

Reset
REQ-029 rst SHALL, on the next edge and from any state including mid-frame, force IDLE, axiov=0, axiod=00, frame_done=0, frame_drop=0, byte_count=0, and clear all buffers and counters.
REQ-030 After rst deasserts, a frame in progress SHALL NOT be accepted; reception resumes only at the next crsdv low-to-preamble start.

Verification
REQ-031 31x01 + 11, dest=MAC_ADDR, 64-byte payload 0x00..0x3F -> axiov high 256 consecutive cycles, first byte out 4 cycles after its last dibit, axiod per byte MSB-first, byte_count=64, one frame_done.
REQ-032 Dest=FF..FF with ALLOW_BROADCAST=1 -> accepted; with ALLOW_BROADCAST=0 -> frame_drop after dibit 23, axiov never high.
REQ-033 Dest mismatching MAC_ADDR in last dibit only -> frame_drop, no axiov, next valid frame accepted normally.
REQ-034 Preamble of 20x01 then 11 -> frame_drop; 28x01 then 11 -> accepted.
REQ-035 Payload of 10 bytes + 2 dibits then crsdv=0 -> exactly 10 bytes emitted, partial dropped, frame_done one cycle after last axiov.
REQ-036 rst asserted mid-payload (byte 5) -> next edge all outputs zero; remaining frame ignored; following frame received correctly with byte_count restarting at 0.
